mult_share_ctrl: RTL and testbench

Sequencer and round-robin arbiter that time-shares one `multiplier` instance among `NUM_REQ` requesters. It grants one requester at a time, registers that requester's operands, and drives the multiplier's `enable` for exactly one cycle. It captures the product into a response register, tagged with the requester index, and holds it until the consumer accepts it. It sits between the PE-side operand producers and the shared `multiplier`, which stays purely combinational.

---
 rtl/mult_share_ctrl.sv | 154 +++++++++++++++
 tb/tb_mult_share_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_ctrl.sv
// Sequencer and arbiter that time-shares one combinational multiplier among NUM_REQ requesters.
// Define MULT_SHARE_RR_EN for round-robin arbitration; otherwise the lowest valid index wins.
module mult_share_ctrl #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ID_W        = $clog2(NUM_REQ),
  parameter int unsigned BIN_LEN     = 8,
  parameter int unsigned OUT_BIN_LEN = 2 * BIN_LEN
) (
  input  logic                            i_clock,
  input  logic                            i_reset,
  input  logic [NUM_REQ-1:0]              i_req_valid,
  input  logic [NUM_REQ-1:0][BIN_LEN-1:0] i_req_val1,
  input  logic [NUM_REQ-1:0][BIN_LEN-1:0] i_req_val2,
  output logic [NUM_REQ-1:0]              o_req_ready,
  output logic [BIN_LEN-1:0]              o_mul_val1,
  output logic [BIN_LEN-1:0]              o_mul_val2,
  output logic                            o_mul_enable,
  input  logic [OUT_BIN_LEN-1:0]          i_mul_result,
  output logic                            o_resp_valid,
  input  logic                            i_resp_ready,
  output logic [OUT_BIN_LEN-1:0]          o_resp_val,
  output logic [ID_W-1:0]                 o_resp_id
);

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StHold
  } state_e;

  state_e               r_state;
  state_e               w_state_next;
  logic                 w_can_accept;
  logic                 w_grant;
  logic                 w_found;
  logic [ID_W-1:0]      w_win_id;
  logic [BIN_LEN-1:0]   r_op1;
  logic [BIN_LEN-1:0]   r_op2;
  logic [ID_W-1:0]      r_id;
  logic [OUT_BIN_LEN-1:0] r_resp_val;
  logic [ID_W-1:0]      r_resp_id;

`ifdef MULT_SHARE_RR_EN
  logic [ID_W-1:0] r_rr_ptr;

  // First search at or above the pointer, then wrap to the bottom of the vector.
  always_comb begin
    w_found  = 1'b0;
    w_win_id = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (!w_found && i_req_valid[i] && (ID_W'(i) >= r_rr_ptr)) begin
        w_found  = 1'b1;
        w_win_id = ID_W'(i);
      end
    end
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (!w_found && i_req_valid[i]) begin
        w_found  = 1'b1;
        w_win_id = ID_W'(i);
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_rr_ptr <= '0;
    end else if (w_grant) begin
      if (w_win_id == ID_W'(NUM_REQ - 1)) begin
        r_rr_ptr <= '0;
      end else begin
        r_rr_ptr <= w_win_id + 1'b1;
      end
    end
  end
`else
  always_comb begin
    w_found  = 1'b0;
    w_win_id = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (!w_found && i_req_valid[i]) begin
        w_found  = 1'b1;
        w_win_id = ID_W'(i);
      end
    end
  end
`endif

  always_comb begin
    w_can_accept = (r_state == StIdle) || ((r_state == StHold) && i_resp_ready);
    w_grant      = w_can_accept && w_found;
    o_req_ready  = '0;
    if (w_grant) begin
      o_req_ready[w_win_id] = 1'b1;
    end
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_grant) begin
          w_state_next = StMul;
        end
      end
      StMul: begin
        w_state_next = StHold;
      end
      StHold: begin
        // Retiring the response and granting a new request share one edge.
        if (w_grant) begin
          w_state_next = StMul;
        end else if (i_resp_ready) begin
          w_state_next = StIdle;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_op1      <= '0;
      r_op2      <= '0;
      r_id       <= '0;
      r_resp_val <= '0;
      r_resp_id  <= '0;
    end else begin
      if (w_grant) begin
        r_op1 <= i_req_val1[w_win_id];
        r_op2 <= i_req_val2[w_win_id];
        r_id  <= w_win_id;
      end
      if (r_state == StMul) begin
        r_resp_val <= i_mul_result;
        r_resp_id  <= r_id;
      end
    end
  end

  assign o_mul_enable = (r_state == StMul);
  assign o_mul_val1   = o_mul_enable ? r_op1 : '0;
  assign o_mul_val2   = o_mul_enable ? r_op2 : '0;
  assign o_resp_valid = (r_state == StHold);
  assign o_resp_val   = r_resp_val;
  assign o_resp_id    = r_resp_id;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Bench for mult_share_ctrl: transaction-level model compared every cycle, plus literal checks.
// Honours MULT_SHARE_RR_EN for the expected arbitration order.
module tb_mult_share_ctrl;

`ifdef MULT_SHARE_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [3:0]      req_valid;
  logic [3:0][7:0] req_val1;
  logic [3:0][7:0] req_val2;
  logic [3:0]      req_ready;
  logic [7:0]      mul_val1;
  logic [7:0]      mul_val2;
  logic            mul_enable;
  logic [15:0]     mul_result;
  logic            resp_valid;
  logic            resp_ready;
  logic [15:0]     resp_val;
  logic [1:0]      resp_id;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit log_en = 1'b0;
  int g_id[$];
  int g_cyc[$];

  always #5 clk = ~clk;

  // Stand-in for the shared combinational multiplier.
  assign mul_result = {8'b0, mul_val1} * {8'b0, mul_val2};

  mult_share_ctrl #(
    .NUM_REQ    (4),
    .ID_W       (2),
    .BIN_LEN    (8),
    .OUT_BIN_LEN(16)
  ) dut (
    .i_clock     (clk),
    .i_reset     (reset),
    .i_req_valid (req_valid),
    .i_req_val1  (req_val1),
    .i_req_val2  (req_val2),
    .o_req_ready (req_ready),
    .o_mul_val1  (mul_val1),
    .o_mul_val2  (mul_val2),
    .o_mul_enable(mul_enable),
    .i_mul_result(mul_result),
    .o_resp_valid(resp_valid),
    .i_resp_ready(resp_ready),
    .o_resp_val  (resp_val),
    .o_resp_id   (resp_id)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Model: one operation in the multiplier stage, one response held for the consumer.
  bit         m_known = 1'b0;
  bit         m_busy, m_held;
  logic [7:0] m_a, m_b;
  int         m_busy_id, m_id, m_ptr;
  logic [15:0] m_val;

  function automatic int pick(input logic [3:0] v, input int ptr);
    int start = RR ? ptr : 0;
    pick = -1;
    for (int k = 0; k < 4; k++) begin
      int idx = (start + k) % 4;
      if (pick < 0 && v[idx]) pick = idx;
    end
  endfunction

  function automatic int model_winner();
    bit can_accept = !m_busy && (!m_held || resp_ready);
    return can_accept ? pick(req_valid, m_ptr) : -1;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      m_known <= 1'b1;
      m_busy  <= 1'b0;
      m_held  <= 1'b0;
      m_val   <= '0;
      m_id    <= 0;
      m_ptr   <= 0;
    end else if (m_known) begin
      if (m_busy) begin
        m_held <= 1'b1;
        m_val  <= {8'b0, m_a} * {8'b0, m_b};
        m_id   <= m_busy_id;
      end else if (m_held && resp_ready) begin
        m_held <= 1'b0;
      end
      if (model_winner() >= 0) begin
        m_busy    <= 1'b1;
        m_a       <= req_val1[model_winner()];
        m_b       <= req_val2[model_winner()];
        m_busy_id <= model_winner();
        m_ptr     <= (model_winner() + 1) % 4;
      end else begin
        m_busy <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      logic [3:0] exp_rdy;
      exp_rdy = (model_winner() < 0) ? 4'b0 : (4'b1 << model_winner());
      chk("no_x", {31'b0, $isunknown({req_ready, mul_val1, mul_val2, mul_enable,
                                      resp_valid, resp_val, resp_id})}, 0);
      chk("req_ready", {28'b0, req_ready}, {28'b0, exp_rdy});
      chk("mul_enable", {31'b0, mul_enable}, {31'b0, m_busy});
      chk("mul_val1", {24'b0, mul_val1}, m_busy ? {24'b0, m_a} : 32'd0);
      chk("mul_val2", {24'b0, mul_val2}, m_busy ? {24'b0, m_b} : 32'd0);
      chk("resp_valid", {31'b0, resp_valid}, {31'b0, m_held});
      if (m_held) begin
        chk("resp_val", {16'b0, resp_val}, {16'b0, m_val});
        chk("resp_id", {30'b0, resp_id}, m_id);
      end
    end
    if (log_en && ((req_ready & req_valid) != 4'b0)) begin
      for (int i = 0; i < 4; i++) begin
        if (req_ready[i]) begin
          g_id.push_back(i);
          g_cyc.push_back(cyc);
        end
      end
    end
  end

  initial begin
    int exp_order[5];
    if (RR) exp_order = '{0, 1, 2, 3, 0};
    else    exp_order = '{0, 0, 0, 0, 0};

    reset = 1'b1; req_valid = '0; req_val1 = '0; req_val2 = '0; resp_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", {28'b0, req_ready}, 0);
    chk("rst_mul_enable", {31'b0, mul_enable}, 0);
    chk("rst_mul_val1", {24'b0, mul_val1}, 0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 0);
    chk("rst_resp_val", {16'b0, resp_val}, 0);
    chk("rst_resp_id", {30'b0, resp_id}, 0);

    // Basic: requester 2 sends 13 x 11.
    tick();
    req_valid = 4'b0100; req_val1[2] = 8'd13; req_val2[2] = 8'd11;
    @(negedge clk);
    chk("basic_grant", {28'b0, req_ready}, 32'b0100);
    tick();
    req_valid = 4'b0000; req_val1[2] = 8'd99; req_val2[2] = 8'd98;
    @(negedge clk);
    chk("basic_enable", {31'b0, mul_enable}, 1);
    chk("basic_op1", {24'b0, mul_val1}, 13);
    chk("basic_op2", {24'b0, mul_val2}, 11);
    tick();
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      req_val1[i] = 8'(i + 3);
      req_val2[i] = 8'(i + 5);
    end
    @(negedge clk);
    chk("basic_resp_val", {16'b0, resp_val}, 143);
    chk("basic_resp_id", {30'b0, resp_id}, 2);
    chk("basic_enable_off", {31'b0, mul_enable}, 0);

    // Backpressure: response held for 5 cycles with every requester asking.
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      @(negedge clk);
      chk("bp_valid", {31'b0, resp_valid}, 1);
      chk("bp_ready", {28'b0, req_ready}, 0);
      chk("bp_val", {16'b0, resp_val}, 143);
      chk("bp_id", {30'b0, resp_id}, 2);
    end

    // Back-to-back: retire and grant 255 x 255 at the same edge.
    tick();
    req_valid = 4'b0010; req_val1[1] = 8'd255; req_val2[1] = 8'd255; resp_ready = 1'b1;
    @(negedge clk);
    chk("b2b_grant", {28'b0, req_ready}, 32'b0010);
    tick();
    req_valid = 4'b0000; resp_ready = 1'b0;
    @(negedge clk);
    chk("b2b_enable", {31'b0, mul_enable}, 1);
    chk("b2b_op1", {24'b0, mul_val1}, 255);
    tick();
    @(negedge clk);
    chk("b2b_valid", {31'b0, resp_valid}, 1);
    chk("b2b_val", {16'b0, resp_val}, 65025);
    chk("b2b_id", {30'b0, resp_id}, 1);
    tick();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    @(negedge clk);
    chk("b2b_idle", {31'b0, resp_valid}, 0);

    // Reset while the multiplier stage is busy.
    tick();
    req_valid = 4'b1000; req_val1[3] = 8'd7; req_val2[3] = 8'd9;
    @(negedge clk);
    chk("rm_grant", {28'b0, req_ready}, 32'b1000);
    tick();
    req_valid = 4'b0000; reset = 1'b1;
    @(negedge clk);
    chk("rm_in_mul", {31'b0, mul_enable}, 1);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rm_enable", {31'b0, mul_enable}, 0);
    chk("rm_op1", {24'b0, mul_val1}, 0);
    chk("rm_resp_val", {16'b0, resp_val}, 0);
    chk("rm_resp_id", {30'b0, resp_id}, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      chk("rm_no_resp", {31'b0, resp_valid}, 0);
    end

    // Fairness: all requesters valid continuously, consumer always ready.
    tick();
    req_valid = 4'b1111; resp_ready = 1'b1; log_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_val1[i] = 8'(i + 1);
      req_val2[i] = 8'(i + 20);
    end
    repeat (10) tick();
    log_en = 1'b0; req_valid = 4'b0000;
    chk("rr_count", 32'(g_id.size()), 5);
    for (int i = 0; i < 5 && i < g_id.size(); i++) begin
      chk("rr_order", g_id[i], exp_order[i]);
      if (i > 0) chk("rr_gap", g_cyc[i] - g_cyc[i-1], 2);
    end

    repeat (3) tick();
    resp_ready = 1'b0;
    tick();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
